// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide beside the execute-stage ALU: radix-2 shift-add
// multiply and restoring divide, one bit per clock, result held until the next completion.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc, w_acc_mul, w_acc_div, w_acc_nx;
  logic [WIDTH:0]  r_mag_a, r_mag_b, w_mag_a, w_mag_b;
  logic [WIDTH:0]  w_mul_hi, w_shift_hi, w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, r_result, w_result;
  logic            r_neg, r_divz, r_exc, w_exc;
  logic            w_start, w_last;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == LAST);

  // 33-bit magnitudes so that -2^31 becomes +2^31 without overflow
  assign w_mag_a = data_operandA[WIDTH-1] ? -{1'b1, data_operandA} : {1'b0, data_operandA};
  assign w_mag_b = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (ctrl_MULT)     w_state_nx = S_MUL;
    else if (ctrl_DIV) w_state_nx = S_DIV;
    else begin
      case (r_state)
        S_MUL, S_DIV: if (w_last) w_state_nx = S_DONE;
        S_DONE:       w_state_nx = S_IDLE;
        default:      w_state_nx = r_state;
      endcase
    end
  end

  // Multiply: accumulator is {upper 33, multiplier/product-low 32}
  assign w_mul_hi  = r_acc[0] ? (r_acc[AW-1:WIDTH] + r_mag_a) : r_acc[AW-1:WIDTH];
  assign w_acc_mul = {1'b0, w_mul_hi, r_acc[WIDTH-1:1]};

  // Divide: accumulator is {remainder 33, quotient 32}; bit 32 of the trial is its sign
  assign w_shift_hi = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_shift_hi - r_mag_b;
  assign w_acc_div  = w_trial[WIDTH] ? {w_shift_hi, r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial,    r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_nx = (r_state == S_MUL) ? w_acc_mul : w_acc_div;
  assign w_prod   = r_neg ? -w_acc_nx[2*WIDTH-1:0] : w_acc_nx[2*WIDTH-1:0];
  assign w_quo    = r_neg ? -w_acc_nx[WIDTH-1:0] : w_acc_nx[WIDTH-1:0];

  always_comb begin
    w_result = '0;
    w_exc    = 1'b0;
    if (r_state == S_MUL) begin
      w_result = w_prod[WIDTH-1:0];
      w_exc    = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
    end else if (r_divz) begin
      w_exc    = 1'b1;
    end else begin
      // only -2^31 / -1 yields a positive quotient magnitude of 2^31
      w_result = w_quo;
      w_exc    = ~r_neg & w_acc_nx[WIDTH-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_acc   <= ctrl_MULT ? AW'(w_mag_b[WIDTH-1:0]) : AW'(w_mag_a[WIDTH-1:0]);
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_divz  <= (data_operandB == '0);
    end else if (r_state == S_MUL || r_state == S_DIV) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_result;
        r_exc    <= w_exc;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: latency, signed results, exceptions, abort, reset and hold.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge with operands scrambled.
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (data_resultRDY) break;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e);
    int edges;
    start(m, d, a, b);
    wait_rdy(edges);
    check({tag, "_lat"}, 32'(edges), 32'd32);
    check({tag, "_res"}, data_result, exp_r);
    check({tag, "_exc"}, 32'(data_exception), 32'(exp_e));
    @(posedge clock);
    @(negedge clock);
    check({tag, "_rdy1"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int edges;
    int rdy_seen;

    repeat (3) @(negedge clock);
    check("rst_res", data_result, 32'd0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul_7xm6",   1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    run_op("mul_ovf",    1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_min",    1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run_op("mul_m3xm5",  1, 0, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 32'd15,        1'b0);
    run_op("div_m100_7", 0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
    run_op("div_100_m9", 0, 1, 32'd100,        32'hFFFF_FFF7, 32'hFFFF_FFF5, 1'b0);
    run_op("div_by0",    0, 1, 32'd5,          32'd0,         32'd0,         1'b1);
    run_op("div_minm1",  0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Abort a multiply at edge 10 with a divide; RDY must count from the restart edge
    start(1'b1, 1'b0, 32'd3, 32'd4);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("abort_norddy", 32'(data_resultRDY), 32'd0);
    end
    start(1'b0, 1'b1, 32'd100, 32'd9);
    wait_rdy(edges);
    check("abort_lat", 32'(edges), 32'd32);
    check("abort_res", data_result, 32'd11);
    check("abort_exc", 32'(data_exception), 32'd0);
    @(posedge clock);
    @(negedge clock);

    run_op("both_ctrl", 1, 1, 32'd6, 32'd7, 32'd42, 1'b0);

    // Asynchronous reset in the middle of a divide
    start(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_res", data_result, 32'd0);
    check("midrst_exc", 32'(data_exception), 32'd0);
    check("midrst_rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("midrst_nordy", 32'(rdy_seen), 32'd0);

    run_op("mul_2x3", 1, 0, 32'd2, 32'd3, 32'd6, 1'b0);

    for (int i = 0; i < 50; i++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      @(posedge clock);
      @(negedge clock);
      check("hold_res", data_result, 32'd6);
      check("hold_exc", 32'(data_exception), 32'd0);
      check("hold_rdy", 32'(data_resultRDY), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
